// File: rtl/usb_tx_packet_builder_if.sv
// Packet request, payload stream and usb_tx byte handshake for usb_tx_packet_builder.
// The builder uses the master modport; the endpoint layer and usb_tx side use slave.
interface usb_tx_packet_builder_if;
  logic       pktStart;
  logic [3:0] pktPid;
  logic       pktHasData;
  logic       pldEmpty;
  logic       pldValid;
  logic [7:0] pldData;
  logic       pldLast;
  logic       pldReady;
  logic       reqSendPacket;
  logic       txAcceptNewData;
  logic [7:0] txData;
  logic       txDataValid;
  logic       txIsLastByte;
  logic       sending;

  modport master (
    input  pktStart, pktPid, pktHasData, pldEmpty,
    input  pldValid, pldData, pldLast,
    input  txAcceptNewData, sending,
    output pldReady, reqSendPacket, txData, txDataValid, txIsLastByte
  );

  modport slave (
    output pktStart, pktPid, pktHasData, pldEmpty,
    output pldValid, pldData, pldLast,
    output txAcceptNewData, sending,
    input  pldReady, reqSendPacket, txData, txDataValid, txIsLastByte
  );
endinterface

// File: rtl/usb_tx_packet_builder.sv
// Frames PID, payload and CRC16 bytes for usb_tx in the clk48 domain and reports completion.
// Optional payload length guard enabled by defining USB_TX_PLD_LEN_CHECK_EN.
module usb_tx_packet_builder #(
  parameter int unsigned MAX_PAYLOAD = 1023
) (
  input  logic                    clk48,
  input  logic                    rst_n,
  input  logic                    usbResetDetect,
  output logic                    busy,
  output logic                    pktDone,
  output logic                    lenError,
  usb_tx_packet_builder_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PID      = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_CRC_LO   = 3'd3,
    S_CRC_HI   = 3'd4,
    S_WAIT_END = 3'd5
  } state_e;

  // USB CRC16, reflected form of 0x8005, data bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[15:1]} ^ 16'hA001;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

  if (MAX_PAYLOAD == 32'd0) begin : g_bad_max
    $error("MAX_PAYLOAD must be at least 1");
  end

  state_e      state_q, state_d;
  logic        has_data_q, has_data_d;
  logic        empty_q, empty_d;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic [15:0] crc_q, crc_d;
  logic        last_loaded_q, last_loaded_d;
  logic        sending_prev_q, sending_prev_d;
  logic        transfer_s, slot_free_s, load_ok_s, overflow_s, load_s;

`ifdef USB_TX_PLD_LEN_CHECK_EN
  localparam int unsigned CNT_W = $clog2(MAX_PAYLOAD + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;
`endif

  // Payload hand-off qualifiers: the byte slot may refill in the same cycle it drains.
  always_comb begin
    transfer_s  = bus.txAcceptNewData & tx_valid_q;
    slot_free_s = ~tx_valid_q | transfer_s;
    load_ok_s   = rst_n & ~usbResetDetect & (state_q == S_PAYLOAD) & slot_free_s
                  & ~last_loaded_q & bus.pldValid;
`ifdef USB_TX_PLD_LEN_CHECK_EN
    overflow_s  = load_ok_s & (cnt_q == CNT_W'(MAX_PAYLOAD));
`else
    overflow_s  = 1'b0;
`endif
    load_s      = load_ok_s & ~overflow_s;
  end

`ifdef USB_TX_PLD_LEN_CHECK_EN
  // Payload byte counter and sticky overflow flag.
  always_comb begin
    len_err_d = len_err_q | overflow_s;
    if (state_q == S_IDLE) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end
`endif

  // Packet sequencer next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    has_data_d     = has_data_q;
    empty_d        = empty_q;
    busy_d         = busy_q;
    req_d          = 1'b0;
    done_d         = 1'b0;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    tx_last_d      = tx_last_q;
    crc_d          = crc_q;
    last_loaded_d  = last_loaded_q;
    sending_prev_d = bus.sending;
    if (usbResetDetect) begin
      state_d       = S_IDLE;
      busy_d        = 1'b0;
      tx_data_d     = 8'h00;
      tx_valid_d    = 1'b0;
      tx_last_d     = 1'b0;
      crc_d         = 16'hFFFF;
      last_loaded_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.pktStart) begin
            has_data_d = bus.pktHasData;
            empty_d    = bus.pldEmpty;
            busy_d     = 1'b1;
            req_d      = 1'b1;
            tx_data_d  = {~bus.pktPid, bus.pktPid};
            tx_valid_d = 1'b1;
            tx_last_d  = ~bus.pktHasData;
            state_d    = S_PID;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PID: begin
          if (!transfer_s) begin
            state_d = S_PID;
          end else if (!has_data_q) begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = S_WAIT_END;
          end else if (empty_q) begin
            tx_data_d  = ~crc_q[7:0];
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            state_d    = S_CRC_LO;
          end else begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          // An overflowing byte is refused, so the byte already sent becomes the last one.
          if (load_s) begin
            tx_data_d     = bus.pldData;
            tx_valid_d    = 1'b1;
            tx_last_d     = 1'b0;
            crc_d         = crc16_byte(crc_q, bus.pldData);
            last_loaded_d = bus.pldLast;
          end else if (slot_free_s && (last_loaded_q || overflow_s)) begin
            tx_data_d     = ~crc_q[7:0];
            tx_valid_d    = 1'b1;
            tx_last_d     = 1'b0;
            last_loaded_d = 1'b0;
            state_d       = S_CRC_LO;
          end else if (transfer_s) begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_CRC_LO: begin
          if (transfer_s) begin
            tx_data_d = ~crc_q[15:8];
            tx_last_d = 1'b1;
            state_d   = S_CRC_HI;
          end else begin
            state_d = S_CRC_LO;
          end
        end
        S_CRC_HI: begin
          if (transfer_s) begin
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            state_d    = S_WAIT_END;
          end else begin
            state_d = S_CRC_HI;
          end
        end
        S_WAIT_END: begin
          if (sending_prev_q && !bus.sending) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            crc_d   = 16'hFFFF;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_END;
          end
        end
        default: begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          tx_data_d  = 8'h00;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      has_data_q     <= 1'b0;
      empty_q        <= 1'b0;
      busy_q         <= 1'b0;
      req_q          <= 1'b0;
      done_q         <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      tx_last_q      <= 1'b0;
      crc_q          <= 16'hFFFF;
      last_loaded_q  <= 1'b0;
      sending_prev_q <= 1'b0;
`ifdef USB_TX_PLD_LEN_CHECK_EN
      cnt_q          <= {CNT_W{1'b0}};
      len_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      has_data_q     <= has_data_d;
      empty_q        <= empty_d;
      busy_q         <= busy_d;
      req_q          <= req_d;
      done_q         <= done_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      tx_last_q      <= tx_last_d;
      crc_q          <= crc_d;
      last_loaded_q  <= last_loaded_d;
      sending_prev_q <= sending_prev_d;
`ifdef USB_TX_PLD_LEN_CHECK_EN
      cnt_q          <= cnt_d;
      len_err_q      <= len_err_d;
`endif
    end
  end

  assign busy              = busy_q;
  assign pktDone           = done_q;
  assign bus.pldReady      = load_s;
  assign bus.reqSendPacket = req_q;
  assign bus.txData        = tx_data_q;
  assign bus.txDataValid   = tx_valid_q;
  assign bus.txIsLastByte  = tx_last_q;
`ifdef USB_TX_PLD_LEN_CHECK_EN
  assign lenError          = len_err_q;
`else
  assign lenError          = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// Scoreboard bench for usb_tx_packet_builder: expected byte streams are queued when a packet is
// requested and an independent monitor compares them with every usb_tx byte transfer.
module tb_usb_tx_packet_builder;
`ifdef USB_TX_PLD_LEN_CHECK_EN
  localparam int MAXP = 8;
`else
  localparam int MAXP = 1023;
`endif
  localparam int RMAX = (MAXP < 16) ? MAXP : 16;

  logic clk48 = 1'b0;
  logic rst_n;
  logic usbResetDetect;
  logic busy, pktDone, lenError;

  usb_tx_packet_builder_if bus();

  usb_tx_packet_builder #(.MAX_PAYLOAD(MAXP)) dut (
    .clk48(clk48), .rst_n(rst_n), .usbResetDetect(usbResetDetect),
    .busy(busy), .pktDone(pktDone), .lenError(lenError), .bus(bus)
  );

  always #10 clk48 = ~clk48;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic [7:0] src_q[$];
  int pops = 0, gap_after = 0, gap_rem = 0, done_cnt = 0, tail = 0;
  bit acc_rand = 1'b0, pld_ready_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {bus.pldReady, busy, pktDone, bus.reqSendPacket, bus.txData,
            bus.txDataValid, bus.txIsLastByte, lenError};
  endfunction

  // Reference CRC: non-reflected 0x8005 division over the wire bit order, then mirrored and inverted.
  function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
    logic [15:0] r;
    logic [15:0] o;
    logic fb;
    r = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ d[k][b];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    for (int i = 0; i < 16; i++) o[i] = r[15 - i];
    return ~o;
  endfunction

  // Monitor: every usb_tx byte transfer is popped against the scoreboard.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk48);
      if (bus.pldReady) pld_ready_seen = 1'b1;
      if (pktDone) done_cnt++;
      if (bus.txAcceptNewData && bus.txDataValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %h with nothing expected", {bus.txIsLastByte, bus.txData});
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'({bus.txIsLastByte, bus.txData}), 32'(e));
        end
      end
    end
  end

  // Environment: payload source, randomized usb_tx acceptance and a usb_tx 'sending' model.
  initial begin
    bit pfire, tlast, start_snd, abort_s;
    bus.pldValid = 1'b0; bus.pldData = 8'h00; bus.pldLast = 1'b0;
    bus.txAcceptNewData = 1'b0; bus.sending = 1'b0;
    forever begin
      @(negedge clk48);
      pfire     = bus.pldValid && bus.pldReady;
      tlast     = bus.txAcceptNewData && bus.txDataValid && bus.txIsLastByte;
      start_snd = bus.reqSendPacket;
      abort_s   = usbResetDetect;
      @(posedge clk48); #1;
      if (gap_rem > 0) gap_rem--;
      if (pfire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        pops++;
        if (pops == gap_after) gap_rem = 5;
      end
      if (src_q.size() > 0) begin
        bus.pldValid = (gap_rem == 0);
        bus.pldData  = src_q[0];
        bus.pldLast  = (src_q.size() == 1);
      end else begin
        bus.pldValid = 1'b0;
        bus.pldData  = 8'h00;
        bus.pldLast  = 1'b0;
      end
      bus.txAcceptNewData = acc_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (abort_s) begin
        bus.sending = 1'b0;
        tail = 0;
      end else begin
        if (start_snd) bus.sending = 1'b1;
        if (tlast) tail = 4;
        if (tail > 0) begin
          tail--;
          if (tail == 0) bus.sending = 1'b0;
        end
      end
    end
  end

  task automatic start_pkt(input logic [3:0] pid, input bit has_data, input logic [7:0] pl[$],
                           input int exp_len, input int gap_at, input logic [16:0] crc_ovr,
                           output int d0);
    logic [7:0] sent[$];
    logic [15:0] crc;
    exp_q.push_back({~has_data, ~pid, pid});
    if (has_data) begin
      for (int i = 0; i < exp_len; i++) begin
        sent.push_back(pl[i]);
        exp_q.push_back({1'b0, pl[i]});
      end
      crc = crc_ovr[16] ? crc_ovr[15:0] : ref_crc(sent);
      exp_q.push_back({1'b0, crc[7:0]});
      exp_q.push_back({1'b1, crc[15:8]});
    end
    src_q = pl; pops = 0; gap_after = gap_at; gap_rem = 0;
    pld_ready_seen = 1'b0;
    d0 = done_cnt;
    @(posedge clk48); #1;
    bus.pktStart = 1'b1; bus.pktPid = pid; bus.pktHasData = has_data;
    bus.pldEmpty = (pl.size() == 0);
    @(posedge clk48); #1;
    bus.pktStart = 1'b0; bus.pktPid = 4'($urandom);
    bus.pktHasData = 1'($urandom); bus.pldEmpty = 1'($urandom);
  endtask

  task automatic send_pkt(input logic [3:0] pid, input bit has_data, input logic [7:0] pl[$],
                          input int exp_len, input int gap_at, input logic [16:0] crc_ovr);
    int d0, t;
    start_pkt(pid, has_data, pl, exp_len, gap_at, crc_ovr, d0);
    repeat (2) @(posedge clk48); #1;
    if (busy) begin
      bus.pktStart = 1'b1; bus.pktPid = 4'h2; bus.pktHasData = 1'b0;
      @(posedge clk48); #1;
      bus.pktStart = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 4000) begin
      @(negedge clk48);
      t++;
    end
    check("pkt_done_seen", 32'(done_cnt - d0), 32'd1);
    repeat (4) @(negedge clk48);
    check("pkt_done_single", 32'(done_cnt - d0), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    int d0, t, len;
    bit hd;
    rst_n = 1'b0; usbResetDetect = 1'b0;
    bus.pktStart = 1'b0; bus.pktPid = 4'h0; bus.pktHasData = 1'b0; bus.pldEmpty = 1'b0;
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    check("reset_outputs", 32'(outs()), 32'd0);
    @(posedge clk48); #1;
    rst_n = 1'b1;

    // ACK: single PID byte, no payload pulled
    acc_rand = 1'b0;
    pl.delete();
    send_pkt(4'h2, 1'b0, pl, 0, 0, 17'h0);
    check("ack_no_pld_ready", 32'(pld_ready_seen), 32'd0);

    // zero-length DATA1: 4B 00 00
    send_pkt(4'hB, 1'b1, pl, 0, 0, {1'b1, 16'h0000});

    // SETUP-style DATA0 with known CRC bytes DD 94, random acceptance spacing
    acc_rand = 1'b1;
    pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    send_pkt(4'h3, 1'b1, pl, 8, 0, {1'b1, 16'h94DD});

    // payload underrun: five idle source cycles after the fourth byte
    pl.delete();
    for (int i = 0; i < RMAX; i++) pl.push_back(8'($urandom));
    send_pkt(4'hB, 1'b1, pl, RMAX, 4, 17'h0);

    // bus reset during PAYLOAD
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    start_pkt(4'h3, 1'b1, pl, 20, 0, 17'h0, d0);
    t = 0;
    while (pops < 3 && t < 2000) begin
      @(negedge clk48);
      t++;
    end
    check("abort_in_payload", 32'(pops >= 3), 32'd1);
    @(posedge clk48); #1;
    usbResetDetect = 1'b1;
    @(posedge clk48); #1;
    usbResetDetect = 1'b0;
    @(negedge clk48);
    check("abort_outputs", 32'(outs() & 15'h7FFE), 32'd0);
    repeat (20) @(negedge clk48);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk48); #1;
    exp_q.delete();
    src_q.delete();
    pl.delete();
    send_pkt(4'h2, 1'b0, pl, 0, 0, 17'h0);

    // randomized packets
    for (int n = 0; n < 10; n++) begin
      hd  = 1'($urandom);
      len = hd ? int'($urandom_range(0, RMAX)) : 0;
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_pkt(4'($urandom), hd, pl, len, int'($urandom_range(0, 6)), 17'h0);
    end

`ifdef USB_TX_PLD_LEN_CHECK_EN
    // oversize payload: only MAXP bytes sent, CRC over those, sticky lenError
    pl.delete();
    for (int i = 0; i < MAXP + 2; i++) pl.push_back(8'($urandom));
    send_pkt(4'h3, 1'b1, pl, MAXP, 0, 17'h0);
    @(posedge clk48); #1;
    src_q.delete();
    check("len_error_set", 32'(lenError), 32'd1);
    pl.delete();
    send_pkt(4'h2, 1'b0, pl, 0, 0, 17'h0);
    check("len_error_sticky", 32'(lenError), 32'd1);
`else
    check("len_error_tied", 32'(lenError), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
